// File: rtl/run_ctrl.sv
// run_ctrl: core reset sequencing, run-cycle counting, halt/timeout
// detection and LED status drive for the board top level.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_pin     in   synchronous active-low reset
//   halt        in   core halt level
//   dbg_val     in   core debug value, shown on led while running
//   core_rst_n  out  active-low core reset, registered
//   running     out  high in RUN
//   done        out  high in DONE (sticky until reset)
//   timed_out   out  high in TIMEOUT (sticky until reset)
//   cycle_count out  RUN cycle counter
//   led         out  registered LED drive
module run_ctrl #(
    parameter int LED_W          = 8,
    parameter int RST_CYCLES     = 10,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int BLINK_DIV      = 4,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_pin,
    input  logic             halt,
    input  logic [LED_W-1:0] dbg_val,
    output logic             core_rst_n,
    output logic             running,
    output logic             done,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_count,
    output logic [LED_W-1:0] led
);

    localparam int HC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(RST_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_HOLD,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_e;

    state_e               state_q, state_d;
    logic [HC_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [BLINK_DIV-1:0] blink_q, blink_d;
    logic                 crst_q, crst_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [LED_W-1:0]     led_q, led_d;
    logic [LED_W-1:0]     cnt_led;

    // Counter value as shown on the LEDs (truncated or zero-extended).
    if (LED_W <= CNT_W) begin : g_led_trunc
        assign cnt_led = cnt_q[LED_W-1:0];
    end else begin : g_led_zext
        assign cnt_led = {{(LED_W-CNT_W){1'b0}}, cnt_q};
    end

    always_ff @(posedge clk) begin
        if (!rst_pin) begin
            state_q    <= S_HOLD;
            hold_cnt_q <= '0;
            blink_q    <= '0;
            crst_q     <= 1'b0;
            cnt_q      <= '0;
            led_q      <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            blink_q    <= blink_d;
            crst_q     <= crst_d;
            cnt_q      <= cnt_d;
            led_q      <= led_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        blink_d    = blink_q;
        crst_d     = crst_q;
        cnt_d      = cnt_q;
        led_d      = led_q;
        unique case (state_q)
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HC_W'(1);
                crst_d     = 1'b0;
                led_d      = '0;
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    crst_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                led_d = dbg_val;
                // Halt beats a coincident timeout; count is held.
                if (halt) begin
                    state_d = S_DONE;
                    led_d   = cnt_led;
                end else if (TO_EN && cnt_q == TO_LAST) begin
                    state_d = S_TIMEOUT;
                    crst_d  = 1'b0;
                    cnt_d   = TO_VAL;
                    led_d   = '1;
                    blink_d = '0;
                end else if (~&cnt_q) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                led_d = cnt_led;
            end
            S_TIMEOUT: begin
                blink_d = blink_q + BLINK_DIV'(1);
                if (&blink_q) begin
                    led_d = ~led_q;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    assign core_rst_n  = crst_q;
    assign running     = (state_q == S_RUN);
    assign done        = (state_q == S_DONE);
    assign timed_out   = (state_q == S_TIMEOUT);
    assign cycle_count = cnt_q;
    assign led         = led_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed bench for run_ctrl with a queue of expected
// output snapshots, one pushed per driven cycle and popped after the edge.
module tb_run_ctrl;

    logic        clk;
    logic        rst_pin;
    logic        halt;
    logic [7:0]  dbg_val;
    logic        core_rst_n;
    logic        running;
    logic        done;
    logic        timed_out;
    logic [31:0] cycle_count;
    logic [7:0]  led;

    run_ctrl #(
        .LED_W(8),
        .RST_CYCLES(10),
        .TIMEOUT_CYCLES(500),
        .BLINK_DIV(2),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .rst_pin(rst_pin),
        .halt(halt),
        .dbg_val(dbg_val),
        .core_rst_n(core_rst_n),
        .running(running),
        .done(done),
        .timed_out(timed_out),
        .cycle_count(cycle_count),
        .led(led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic        crst;
        logic        run;
        logic        dn;
        logic        to;
        logic [31:0] cnt;
        logic [7:0]  led;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   fails   = 0;

    task automatic chk_bit(input string tag, input string f,
                           input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s observed=%0b expected=%0b", tag, f, obs, exp);
        end
    endtask

    task automatic check_one();
        exp_t e;
        if (sb.size() == 0) begin
            vectors++;
            fails++;
            $error("FAIL scoreboard observed=empty expected=entry");
            return;
        end
        e = sb.pop_front();
        chk_bit(e.tag, "core_rst_n", core_rst_n, e.crst);
        chk_bit(e.tag, "running", running, e.run);
        chk_bit(e.tag, "done", done, e.dn);
        chk_bit(e.tag, "timed_out", timed_out, e.to);
        vectors++;
        assert (cycle_count === e.cnt) else begin
            fails++;
            $error("FAIL %s.cycle_count observed=%0d expected=%0d",
                   e.tag, cycle_count, e.cnt);
        end
        vectors++;
        assert (led === e.led) else begin
            fails++;
            $error("FAIL %s.led observed=%02h expected=%02h",
                   e.tag, led, e.led);
        end
    endtask

    // Push the expectation for the coming edge, clock, then compare.
    task automatic cyc(input string tag, input logic crst, input logic run,
                       input logic dn, input logic to,
                       input logic [31:0] cnt, input logic [7:0] l);
        exp_t e;
        e.tag  = tag;
        e.crst = crst;
        e.run  = run;
        e.dn   = dn;
        e.to   = to;
        e.cnt  = cnt;
        e.led  = l;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_one();
    endtask

    // Release reset and walk the hold phase up to RUN with count 0.
    task automatic hold_to_run(input logic pulse_halt);
        rst_pin = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            halt = pulse_halt && (k >= 3) && (k <= 8);
            dbg_val = 8'hC3;
            cyc("hold", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00);
        end
        halt = 1'b0;
        cyc("hold_exit", 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 8'h00);
    endtask

    // Run n cycles without halt, dbg_val changing every cycle.
    task automatic run_n(input int n);
        logic [7:0] d;
        for (int i = 1; i <= n; i++) begin
            d = 8'(i * 7 + 3);
            dbg_val = d;
            cyc("run", 1'b1, 1'b1, 1'b0, 1'b0, 32'(i), d);
        end
    endtask

    initial begin
        rst_pin = 1'b0;
        halt    = 1'b0;
        dbg_val = 8'h00;
        #1;
        for (int k = 0; k < 10; k++)
            cyc("reset", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00);

        // Halt pulsed during hold is ignored.
        hold_to_run(1'b1);
        dbg_val = 8'h5A;
        cyc("dbg_5a", 1'b1, 1'b1, 1'b0, 1'b0, 32'd1, 8'h5A);
        dbg_val = 8'h5A;
        for (int i = 2; i <= 37; i++)
            cyc("run37", 1'b1, 1'b1, 1'b0, 1'b0, 32'(i), 8'h5A);
        halt = 1'b1;
        cyc("halt37", 1'b1, 1'b0, 1'b1, 1'b0, 32'd37, 8'h25);
        halt = 1'b0;
        for (int k = 0; k < 4; k++)
            cyc("done_hold", 1'b1, 1'b0, 1'b1, 1'b0, 32'd37, 8'h25);

        // Reset out of DONE, then run into timeout.
        rst_pin = 1'b0;
        cyc("rst_done", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00);
        hold_to_run(1'b0);
        run_n(499);
        dbg_val = 8'h11;
        cyc("timeout", 1'b0, 1'b0, 1'b0, 1'b1, 32'd500, 8'hFF);
        for (int j = 1; j <= 12; j++)
            cyc("blink", 1'b0, 1'b0, 1'b0, 1'b1, 32'd500,
                (((j / 4) % 2) == 0) ? 8'hFF : 8'h00);

        // Reset out of TIMEOUT; halt coincident with timeout wins.
        rst_pin = 1'b0;
        cyc("rst_to", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00);
        hold_to_run(1'b0);
        run_n(499);
        halt = 1'b1;
        cyc("halt499", 1'b1, 1'b0, 1'b1, 1'b0, 32'd499, 8'hF3);
        halt = 1'b0;
        cyc("done499", 1'b1, 1'b0, 1'b1, 1'b0, 32'd499, 8'hF3);

        // One-edge reset in the middle of RUN.
        rst_pin = 1'b0;
        cyc("rst_d499", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00);
        hold_to_run(1'b0);
        run_n(100);
        rst_pin = 1'b0;
        dbg_val = 8'hEE;
        cyc("rst_run", 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'h00);
        hold_to_run(1'b0);
        run_n(3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
